// File: rtl/lap_stopwatch_if.sv
// Control pulses and display/status bus of the lap stopwatch.
interface lap_stopwatch_if;
  logic       iTickEn;
  logic       iRunStop;
  logic       iLap;
  logic       iClear;
  logic       iNext;
  logic       iPrev;
  logic [6:0] oHour;
  logic [6:0] oMin;
  logic [6:0] oSec;
  logic [6:0] oCentisec;
  logic [1:0] oState;
  logic       oViewing;
  logic [6:0] oViewIdx;
  logic [6:0] oCount;
  logic       oFull;

  modport master (
    output iTickEn, iRunStop, iLap, iClear, iNext, iPrev,
    input  oHour, oMin, oSec, oCentisec, oState, oViewing, oViewIdx, oCount, oFull
  );

  modport slave (
    input  iTickEn, iRunStop, iLap, iClear, iNext, iPrev,
    output oHour, oMin, oSec, oCentisec, oState, oViewing, oViewIdx, oCount, oFull
  );
endinterface

// File: rtl/lap_stopwatch.sv
// 100 Hz stopwatch with a DEPTH-entry lap memory and a lap viewer active while stopped.
module lap_stopwatch #(
  parameter int unsigned DEPTH     = 30,
  parameter int unsigned HOUR_MAX  = 99,
  parameter int unsigned OVERWRITE = 0
) (
  input logic             iClk,
  input logic             iRstn,
  lap_stopwatch_if.slave  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;

  state_t        state;
  logic [6:0]    hour, min, sec, cs;
  logic [6:0]    nHour, nMin, nSec, nCs;
  logic [6:0]    count;
  logic [6:0]    viewIdx;
  logic          viewing;
  logic [PW-1:0] wrPtr;
  logic [27:0]   laps [DEPTH];

  logic          full;
  logic          doRunStop, doLap, doNext, doPrev;
  logic          lapWrite, viewOk;
  logic [PW-1:0] oldest, rdAddr;
  logic [7:0]    sum, wrapped;
  logic [27:0]   shown;

  assign full      = (count == 7'(DEPTH));
  assign doRunStop = !bus.iClear && bus.iRunStop;
  assign doLap     = !bus.iClear && !bus.iRunStop && bus.iLap;
  assign doNext    = !bus.iClear && !bus.iRunStop && !bus.iLap && bus.iNext;
  assign doPrev    = !bus.iClear && !bus.iRunStop && !bus.iLap && !bus.iNext && bus.iPrev;
  assign lapWrite  = (state == RUN) && (doRunStop || doLap) && (!full || (OVERWRITE != 0));
  assign viewOk    = (state == STOP) && (count != 7'd0);

  always_comb begin
    nCs   = cs;
    nSec  = sec;
    nMin  = min;
    nHour = hour;
    if (cs == 7'd99) begin
      nCs = '0;
      if (sec == 7'd59) begin
        nSec = '0;
        if (min == 7'd59) begin
          nMin = '0;
          nHour = (hour == 7'(HOUR_MAX)) ? '0 : hour + 7'd1;
        end else begin
          nMin = min + 7'd1;
        end
      end else begin
        nSec = sec + 7'd1;
      end
    end else begin
      nCs = cs + 7'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn || bus.iClear) begin
      state   <= IDLE;
      hour    <= '0;
      min     <= '0;
      sec     <= '0;
      cs      <= '0;
      count   <= '0;
      wrPtr   <= '0;
      viewing <= 1'b0;
      viewIdx <= '0;
    end else begin
      if (state == RUN && bus.iTickEn) begin
        hour <= nHour;
        min  <= nMin;
        sec  <= nSec;
        cs   <= nCs;
      end
      if (lapWrite) begin
        wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
        if (!full) count <= count + 7'd1;
      end
      if (doRunStop) begin
        unique case (state)
          IDLE:    state <= RUN;
          RUN:     state <= STOP;
          default: begin
            state   <= RUN;
            viewing <= 1'b0;
            viewIdx <= '0;
          end
        endcase
      end else if (viewOk) begin
        if (doNext) begin
          if (!viewing) begin
            viewing <= 1'b1;
            viewIdx <= '0;
          end else if (viewIdx + 7'd1 < count) begin
            viewIdx <= viewIdx + 7'd1;
          end
        end else if (doPrev && viewing) begin
          if (viewIdx == 7'd0) viewing <= 1'b0;
          else                 viewIdx <= viewIdx - 7'd1;
        end
      end
    end
  end

  // Lap memory has no reset; gating on iRstn keeps a reset edge from landing a partial lap.
  always_ff @(posedge iClk) begin
    if (iRstn && !bus.iClear && lapWrite) laps[wrPtr] <= {hour, min, sec, cs};
  end

  // Until the memory first fills, slot 0 is the oldest; afterwards the write pointer is.
  assign oldest  = full ? wrPtr : '0;
  assign sum     = 8'(oldest) + {1'b0, viewIdx};
  assign wrapped = (sum >= 8'(DEPTH)) ? sum - 8'(DEPTH) : sum;
  assign rdAddr  = PW'(wrapped);
  assign shown   = laps[rdAddr];

  assign bus.oHour     = viewing ? shown[27:21] : hour;
  assign bus.oMin      = viewing ? shown[20:14] : min;
  assign bus.oSec      = viewing ? shown[13:7]  : sec;
  assign bus.oCentisec = viewing ? shown[6:0]   : cs;
  assign bus.oState    = state;
  assign bus.oViewing  = viewing;
  assign bus.oViewIdx  = viewIdx;
  assign bus.oCount    = count;
  assign bus.oFull     = full;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: two DEPTH=4 instances, drop-when-full and overwrite.
module tb_lap_stopwatch;
  logic iClk = 1'b0;
  logic iRstn = 1'b0;

  always #5 iClk = ~iClk;

  lap_stopwatch_if busA ();
  lap_stopwatch_if busB ();

  lap_stopwatch #(.DEPTH(4), .HOUR_MAX(99), .OVERWRITE(0)) dutA (.iClk(iClk), .iRstn(iRstn), .bus(busA));
  lap_stopwatch #(.DEPTH(4), .HOUR_MAX(99), .OVERWRITE(1)) dutB (.iClk(iClk), .iRstn(iRstn), .bus(busB));

  logic [31:0] dispA, dispB;
  assign dispA = {4'd0, busA.oHour, busA.oMin, busA.oSec, busA.oCentisec};
  assign dispB = {4'd0, busB.oHour, busB.oMin, busB.oSec, busB.oCentisec};

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] tw(input int h, input int m, input int s, input int c);
    return {4'd0, 7'(h), 7'(m), 7'(s), 7'(c)};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_empty: got %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      checkVal(e.tag, obs, e.exp);
    end
  endtask

  task automatic drive(input logic t, input logic rs, input logic lp,
                       input logic cl, input logic nx, input logic pv);
    busA.iTickEn = t;  busA.iRunStop = rs; busA.iLap = lp;
    busA.iClear  = cl; busA.iNext    = nx; busA.iPrev = pv;
    busB.iTickEn = t;  busB.iRunStop = rs; busB.iLap = lp;
    busB.iClear  = cl; busB.iNext    = nx; busB.iPrev = pv;
  endtask

  task automatic step(input logic t, input logic rs, input logic lp,
                      input logic cl, input logic nx, input logic pv);
    drive(t, rs, lp, cl, nx, pv);
    @(posedge iClk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) @(posedge iClk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int aSec[5] = '{1, 2, 3, 4, 4};
  int aIdx[5] = '{0, 1, 2, 3, 3};

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    iRstn = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRstn = 1'b1;

    pushExp("rst_state", 32'd0); pushExp("rst_disp", 32'd0);
    pushExp("rst_count", 32'd0); pushExp("rst_full", 32'd0); pushExp("rst_view", 32'd0);
    popCheck(32'(busA.oState)); popCheck(dispA);
    popCheck(32'(busA.oCount)); popCheck(32'(busA.oFull)); popCheck(32'(busA.oViewing));

    // Run for 6123 ticks
    step(0, 1, 0, 0, 0, 0);
    pushExp("run_state", 32'd1);
    popCheck(32'(busA.oState));
    ticks(6123);
    pushExp("run_disp", tw(0, 1, 1, 23)); pushExp("run_state2", 32'd1);
    popCheck(dispA); popCheck(32'(busA.oState));

    step(0, 0, 0, 1, 0, 0);
    pushExp("clr_state", 32'd0); pushExp("clr_disp", 32'd0);
    popCheck(32'(busA.oState)); popCheck(dispA);

    // Lap coincident with a tick at 59.99 s
    step(0, 1, 0, 0, 0, 0);
    ticks(5999);
    pushExp("pre_disp", tw(0, 0, 59, 99));
    popCheck(dispA);
    step(1, 0, 1, 0, 0, 0);
    pushExp("lap_live", tw(0, 1, 0, 0)); pushExp("lap_count", 32'd1);
    popCheck(dispA); popCheck(32'(busA.oCount));
    step(0, 1, 0, 0, 0, 0);
    pushExp("stop_state", 32'd2); pushExp("stop_count", 32'd2);
    popCheck(32'(busA.oState)); popCheck(32'(busA.oCount));
    step(0, 0, 0, 0, 1, 0);
    pushExp("v0_view", 32'd1); pushExp("v0_idx", 32'd0); pushExp("v0_disp", tw(0, 0, 59, 99));
    popCheck(32'(busA.oViewing)); popCheck(32'(busA.oViewIdx)); popCheck(dispA);
    step(0, 0, 0, 0, 1, 0);
    pushExp("v1_idx", 32'd1); pushExp("v1_disp", tw(0, 1, 0, 0));
    popCheck(32'(busA.oViewIdx)); popCheck(dispA);
    step(0, 0, 0, 0, 1, 0);
    pushExp("v1_sat", 32'd1);
    popCheck(32'(busA.oViewIdx));
    step(0, 0, 0, 0, 0, 1);
    pushExp("p_idx", 32'd0);
    popCheck(32'(busA.oViewIdx));
    step(0, 0, 0, 0, 0, 1);
    pushExp("p_view", 32'd0); pushExp("p_live", tw(0, 1, 0, 0));
    popCheck(32'(busA.oViewing)); popCheck(dispA);

    // Four laps at 1..4 s, fifth captured by the stop at 5 s
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ticks(100);
      step(0, 0, 1, 0, 0, 0);
    end
    pushExp("fill_cntA", 32'd4); pushExp("fill_fullA", 32'd1); pushExp("fill_cntB", 32'd4);
    popCheck(32'(busA.oCount)); popCheck(32'(busA.oFull)); popCheck(32'(busB.oCount));
    ticks(100);
    step(0, 1, 0, 0, 0, 0);
    pushExp("full_cntA", 32'd4); pushExp("full_cntB", 32'd4); pushExp("full_fullB", 32'd1);
    popCheck(32'(busA.oCount)); popCheck(32'(busB.oCount)); popCheck(32'(busB.oFull));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      pushExp($sformatf("nextA%0d_disp", i), tw(0, 0, aSec[i], 0));
      pushExp($sformatf("nextA%0d_idx", i), 32'(aIdx[i]));
      popCheck(dispA); popCheck(32'(busA.oViewIdx));
      if (i == 0) begin
        pushExp("nextB0_disp", tw(0, 0, 2, 0));
        popCheck(dispB);
      end
      if (i == 3) begin
        pushExp("nextB3_disp", tw(0, 0, 5, 0)); pushExp("nextB3_idx", 32'd3);
        popCheck(dispB); popCheck(32'(busB.oViewIdx));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (i < 3) begin
        pushExp($sformatf("prevA%0d_idx", i), 32'(2 - i));
        popCheck(32'(busA.oViewIdx));
      end else begin
        pushExp("prevA_view", 32'd0); pushExp("prevA_live", tw(0, 0, 5, 0));
        popCheck(32'(busA.oViewing)); popCheck(dispA);
      end
    end

    // Clear wins over run/stop
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    ticks(50);
    step(0, 1, 0, 1, 0, 0);
    pushExp("cr_state", 32'd0); pushExp("cr_disp", 32'd0); pushExp("cr_count", 32'd0);
    popCheck(32'(busA.oState)); popCheck(dispA); popCheck(32'(busA.oCount));

    // Reset mid-run, coincident with a lap pulse
    step(0, 1, 0, 0, 0, 0);
    ticks(1000);
    pushExp("r10_disp", tw(0, 0, 10, 0));
    popCheck(dispA);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    iRstn = 1'b0;
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp("rr_state", 32'd0); pushExp("rr_disp", 32'd0); pushExp("rr_count", 32'd0);
    pushExp("rr_full", 32'd0); pushExp("rr_view", 32'd0); pushExp("rr_idx", 32'd0);
    popCheck(32'(busA.oState)); popCheck(dispA); popCheck(32'(busA.oCount));
    popCheck(32'(busA.oFull)); popCheck(32'(busA.oViewing)); popCheck(32'(busA.oViewIdx));

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
